flattening_buffer: RTL
======================

Name: flattening_buffer

Overview:
Multi-channel, double-buffered successor to the single-channel flattening PE. It collects ImageSize serial pixels on each of NumChannels parallel lanes and packs them into one flat vector for the dense layer. A two-bank ping-pong store with valid/ready handshakes on both sides lets the next frame fill while the current one waits for the consumer. It sits between the last convolution/pooling stage and the first fully-connected layer.

Parameters:
BitSize, 2, bits per pixel.
ImageSize, 9, pixels per channel per frame.
NumChannels, 4, parallel input lanes.
Delay, 0, accepted beats discarded after reset, to absorb pipeline fill.
NumFrames, 1, output handshakes counted before out_done fires; must be at least 1.

Ports:
clk  in  1  clock, rising edge.
res  in  1  asynchronous, active-high reset.
in_valid  in  1  in_data beat valid.
in_ready  out  1  buffer can accept a beat.
in_data  in  [NumChannels-1:0][BitSize-1:0]  one pixel per lane.
out_valid  out  1  out_data holds a complete frame.
out_ready  in  1  consumer accepts the frame.
out_data  out  [NumChannels*ImageSize-1:0][BitSize-1:0]  flattened frame.
out_done  out  1  one-cycle pulse after the NumFrames-th output handshake.

Behaviour:
- Reset (async assert, sync release) sets the following:
  - Both banks empty, wr_sel=0, rd_sel=0, wr_cnt=0.
  - skip_cnt=Delay, frame_cnt=0.
  - out_valid=0, out_done=0, out_data='0.
  - in_ready=0 while res is high.
- Reset mid-frame discards all partial and full banks. There is no flush.
- Input accept: a beat is accepted when in_valid && in_ready.
- in_ready=1 unless both banks are full.
- Skip phase (skip_cnt>0): in_ready=1. Each accepted beat decrements skip_cnt, and its data is dropped.
- Fill: pixel k of a frame (k = wr_cnt, 0-based arrival order) on lane c is written to bank[wr_sel] index c*ImageSize + (ImageSize-1-k). The first pixel sits at the top of each channel slice.
- An accepted beat with wr_cnt==ImageSize-1 does three things:
  - marks bank[wr_sel] full,
  - toggles wr_sel,
  - sets wr_cnt=0.
- Other accepted beats increment wr_cnt.
- in_valid low holds all state.
- Output: out_valid = bank[rd_sel] full, registered.
  - out_data = bank[rd_sel] contents while out_valid=1, else '0.
  - out_data stays stable while out_valid && !out_ready.
- Output handshake (out_valid && out_ready) marks bank[rd_sel] empty and toggles rd_sel.
- Latency: the last beat of a frame accepted at edge t gives out_valid=1 after edge t+1 if the read bank was empty.
- Throughput: one frame per ImageSize accepted beats with out_ready held high. No bubbles.
- Simultaneous events are allowed in the same cycle:
  - a fill completing into one bank and a handshake draining the other;
  - a handshake freeing the only full bank while the other bank is mid-fill.
- in_ready recomputes from registered bank state. A handshake in cycle t re-enables in_ready in cycle t+1, with no combinational ready path.
- Frame counter:
  - frame_cnt increments on each output handshake and saturates at NumFrames.
  - out_done=1 for exactly one cycle after the handshake that brings frame_cnt to NumFrames.
  - out_done never fires again until reset.
- Width rules:
  - wr_cnt is $clog2(ImageSize+1) bits.
  - skip_cnt is $clog2(Delay+1) bits; when Delay=0 it is absent and the skip phase never occurs.
  - frame_cnt is $clog2(NumFrames+1) bits.

Test Plan:
- Defaults, Delay=0, out_ready=1, lane c beat k = (k+c)%4 for 9 beats -> out_valid high one cycle after beat 9. out_data[c*9+8]=c%4 and out_data[c*9+0]=(8+c)%4. out_done pulses after the handshake.
- Delay=2, 11 beats -> first 2 beats are discarded, and the frame contains beats 3..11 in order.
- out_ready=0, 27 beats offered -> in_ready drops after beat 18. out_data stays stable on frame 1. Raising out_ready drains frame 1 then frame 2. in_ready returns one cycle after the first handshake.
- Continuous input, out_ready=1, NumFrames=3 -> out_valid every 9 cycles, no input stalls, out_done pulses once after the third handshake.
- res asserted asynchronously after beat 5 -> outputs clear immediately with in_ready=0. After release, a full 9-beat frame is produced with no residue from the aborted frame.

Source files
------------

// File: rtl/flattening_buffer.sv
// flattening_buffer: ping-pong packer of per-lane serial pixels into one flat frame
module flattening_buffer #(
  parameter int BitSize     = 2,
  parameter int ImageSize   = 9,
  parameter int NumChannels = 4,
  parameter int Delay       = 0,
  parameter int NumFrames   = 1
) (
  input  logic                                          clk,
  input  logic                                          res,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NumChannels-1:0][BitSize-1:0]           in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NumChannels*ImageSize-1:0][BitSize-1:0] out_data,
  output logic                                          out_done
);
  localparam int FlatSize = NumChannels * ImageSize;
  localparam int IdxW = FlatSize > 1 ? $clog2(FlatSize) : 1;
  localparam int CntW = $clog2(ImageSize + 1);
  localparam int FrmW = $clog2(NumFrames + 1);
  logic [FlatSize-1:0][BitSize-1:0] bank [2];
  logic [1:0] full;
  logic wr_sel, rd_sel, skipping, accept, fill, last, hs;
  logic [CntW-1:0] wr_cnt;
  logic [FrmW-1:0] frame_cnt;
  assign in_ready = !res && !(&full);
  assign accept = in_valid && in_ready;
  assign fill = accept && !skipping;
  assign last = fill && wr_cnt == CntW'(ImageSize - 1);
  assign hs = out_valid && out_ready;
  assign out_data = out_valid ? bank[rd_sel] : '0;
  if (Delay > 0) begin : g_skip
    localparam int SkW = $clog2(Delay + 1);
    logic [SkW-1:0] skip_cnt;
    // drop the first Delay accepted beats after reset to absorb upstream pipeline fill
    always_ff @(posedge clk or posedge res)
      if (res) skip_cnt <= SkW'(Delay);
      else if (accept && skip_cnt != '0) skip_cnt <= skip_cnt - 1'b1;
    assign skipping = skip_cnt != '0;
  end else begin : g_noskip
    assign skipping = 1'b0;
  end
  // pixel k of lane c lands at the top of its slice, counting downward
  always_ff @(posedge clk)
    if (fill)
      for (int c = 0; c < NumChannels; c++)
        bank[wr_sel][IdxW'(c * ImageSize + ImageSize - 1 - int'(wr_cnt))] <= in_data[c];
  // bank occupancy, pointers and frame counting; out_valid looks past a draining bank so full banks go back to back
  always_ff @(posedge clk or posedge res)
    if (res) begin
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_cnt    <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
      out_done  <= 1'b0;
    end else begin
      if (fill) wr_cnt <= last ? '0 : wr_cnt + 1'b1;
      if (last) wr_sel <= !wr_sel;
      if (last) full[wr_sel] <= 1'b1;
      if (hs) full[rd_sel] <= 1'b0;
      if (hs) rd_sel <= !rd_sel;
      out_valid <= hs ? full[!rd_sel] : full[rd_sel];
      if (hs && frame_cnt != FrmW'(NumFrames)) frame_cnt <= frame_cnt + 1'b1;
      out_done <= hs && frame_cnt == FrmW'(NumFrames - 1);
    end
endmodule
